// File: rtl/sampler_frame_ctrl.sv
// Serial frame sampler: synchronizes 'signal', times start/data/marker/stop bits at mid-bit,
// tracks the header/body/payload frame sequence and hands the payload over valid/ready.
module sampler_frame_ctrl #(
    parameter int CLKS_PER_BIT = 128,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 signal,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [1:0]           seq_state,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_MARK, S_STOP} bit_state_t;
    typedef enum logic [1:0] {SEQ_HDR = 2'd0, SEQ_BODY = 2'd1, SEQ_PAYLOAD = 2'd2} seq_t;

    bit_state_t           state, state_next;
    seq_t                 seq_q, seq_next;
    logic [1:0]           sync_ff;
    logic                 sig_prev;
    logic                 sig_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 marker_q;
    logic                 at_half, at_full, fall, cnt_clr;
    logic                 stop_sample, bad_stop, deliver;

    assign sig_s     = sync_ff[1];
    assign fall      = sig_prev & ~sig_s;
    assign at_half   = (cnt == HALF_LAST);
    assign at_full   = (cnt == FULL_LAST);
    assign busy      = (state != S_IDLE);
    assign seq_state = seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff  <= 2'b11;
            sig_prev <= 1'b1;
        end else begin
            sync_ff  <= {sync_ff[0], signal};
            sig_prev <= sync_ff[1];
        end
    end

    always_comb begin
        state_next  = state;
        seq_next    = seq_q;
        stop_sample = 1'b0;
        bad_stop    = 1'b0;
        deliver     = 1'b0;
        cnt_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (enable && fall) state_next = S_START;
            end
            S_START: if (at_half) begin
                cnt_clr    = 1'b1;
                state_next = sig_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (at_full && bit_cnt == LAST_BIT) state_next = S_MARK;
            S_MARK: if (at_full) state_next = S_STOP;
            S_STOP: if (at_full) begin
                state_next  = S_IDLE;
                stop_sample = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (at_full) cnt_clr = 1'b1;

        // A frame with a bad stop bit never advances the sequence; it restarts the hunt for a header.
        if (stop_sample && !sig_s) begin
            bad_stop = 1'b1;
            seq_next = SEQ_HDR;
        end else if (stop_sample) begin
            case (seq_q)
                SEQ_HDR:  seq_next = marker_q ? SEQ_BODY : SEQ_HDR;
                SEQ_BODY: seq_next = marker_q ? SEQ_HDR : SEQ_PAYLOAD;
                SEQ_PAYLOAD: begin
                    seq_next = marker_q ? SEQ_BODY : SEQ_HDR;
                    deliver  = ~marker_q;
                end
                default:  seq_next = SEQ_HDR;
            endcase
        end

        if (!enable) begin
            state_next = S_IDLE;
            seq_next   = SEQ_HDR;
            cnt_clr    = 1'b1;
            bad_stop   = 1'b0;
            deliver    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            seq_q <= SEQ_HDR;
        end else begin
            state <= state_next;
            seq_q <= seq_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            marker_q <= 1'b0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (at_full) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shift_q <= {sig_s, shift_q[DATA_BITS-1:1]};
            end
            if (state == S_MARK && at_full) marker_q <= sig_s;
        end
    end

    // A pending word is never overwritten unless the consumer takes it on this same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            overrun   <= deliver && out_valid && !out_ready;
            if (deliver && (!out_valid || out_ready)) begin
                out_data  <= shift_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sampler_frame_ctrl.sv
// Directed bench for sampler_frame_ctrl: frames are driven bit by bit and delivered
// payloads are checked by a queue-based monitor, alongside directed state checks.
module tb_sampler_frame_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       signal = 1'b1;
    logic       enable = 1'b1;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic [1:0] seq_state;
    logic       frame_err;
    logic       overrun;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   feCycles = 0;
    int   ovCycles = 0;
    int   feBase, ovBase, startCyc;

    sampler_frame_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .signal    (signal),
        .enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .seq_state (seq_state),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Drives nBits bit periods of {stop, marker, data, start} starting at a falling clock edge.
    task automatic applyStimulus(input logic [7:0] data, input logic marker, input logic stopBit,
                                 input int nBits);
        logic [10:0] fb;
        fb = {stopBit, marker, data, 1'b0};
        for (int b = 0; b < nBits; b++) begin
            signal = fb[b];
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Monitor: counts pulse cycles and pops the scoreboard on every accepted word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) feCycles++;
            if (overrun) ovCycles++;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_delivery: got 0x%0h, want no word", out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_data", 32'(out_data), 32'(e.data));
                    if (e.cyc >= 0) checkOutput("sb_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(out_valid), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_data", 32'(out_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_seq", 32'(seq_state), 0);
        checkOutput("reset_ferr", 32'(frame_err), 0);
        checkOutput("reset_ovr", 32'(overrun), 0);

        // 1: header/body/payload with ready high, fixed delivery latency
        $display("[TB] test 1: basic delivery");
        applyStimulus(8'h00, 1'b1, 1'b1, 11);
        checkOutput("t1_seq_after_hdr", 32'(seq_state), 1);
        applyStimulus(8'hFF, 1'b0, 1'b1, 11);
        checkOutput("t1_seq_after_body", 32'(seq_state), 2);
        startCyc = cyc;
        expQ.push_back('{8'hA5, startCyc + 171});
        applyStimulus(8'hA5, 1'b0, 1'b1, 11);
        checkOutput("t1_seq_after_payload", 32'(seq_state), 0);
        checkOutput("t1_valid_cleared", 32'(out_valid), 0);

        // 2: short low glitch is rejected at the half-bit resample
        $display("[TB] test 2: glitch");
        repeat (CPB) @(negedge clk);
        feBase = feCycles;
        signal = 1'b0;
        repeat (4) @(negedge clk);
        signal = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t2_busy_in_start", 32'(busy), 1);
        repeat (3) @(negedge clk);
        checkOutput("t2_busy_dropped", 32'(busy), 0);
        repeat (CPB * 2) @(negedge clk);
        checkOutput("t2_seq", 32'(seq_state), 0);
        checkOutput("t2_no_ferr", 32'(feCycles - feBase), 0);
        checkOutput("t2_no_valid", 32'(out_valid), 0);

        // 3: bad stop bit in the body frame
        $display("[TB] test 3: frame error");
        feBase = feCycles;
        applyStimulus(8'h12, 1'b1, 1'b1, 11);
        checkOutput("t3_seq_body", 32'(seq_state), 1);
        applyStimulus(8'h34, 1'b0, 1'b0, 11);
        signal = 1'b1;
        checkOutput("t3_ferr_pulses", 32'(feCycles - feBase), 1);
        checkOutput("t3_seq_hdr", 32'(seq_state), 0);
        checkOutput("t3_no_valid", 32'(out_valid), 0);
        repeat (CPB) @(negedge clk);

        // 4: consumer stalled across two complete sequences
        $display("[TB] test 4: overrun");
        out_ready = 1'b0;
        ovBase = ovCycles;
        expQ.push_back('{8'h11, -1});
        applyStimulus(8'h00, 1'b1, 1'b1, 11);
        applyStimulus(8'h00, 1'b0, 1'b1, 11);
        applyStimulus(8'h11, 1'b0, 1'b1, 11);
        applyStimulus(8'h00, 1'b1, 1'b1, 11);
        applyStimulus(8'h00, 1'b0, 1'b1, 11);
        applyStimulus(8'h22, 1'b0, 1'b1, 11);
        checkOutput("t4_valid_held", 32'(out_valid), 1);
        checkOutput("t4_data_kept", 32'(out_data), 32'h11);
        checkOutput("t4_ovr_pulses", 32'(ovCycles - ovBase), 1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t4_valid_after_accept", 32'(out_valid), 0);
        checkOutput("t4_queue_drained", 32'(expQ.size()), 0);

        // 5: a marker of 1 during payload restarts as a new header
        $display("[TB] test 5: resync");
        applyStimulus(8'h01, 1'b1, 1'b1, 11);
        checkOutput("t5_seq_a", 32'(seq_state), 1);
        applyStimulus(8'h02, 1'b0, 1'b1, 11);
        checkOutput("t5_seq_b", 32'(seq_state), 2);
        applyStimulus(8'h03, 1'b1, 1'b1, 11);
        checkOutput("t5_seq_c", 32'(seq_state), 1);
        applyStimulus(8'h04, 1'b0, 1'b1, 11);
        checkOutput("t5_seq_d", 32'(seq_state), 2);
        startCyc = cyc;
        expQ.push_back('{8'h3C, startCyc + 171});
        applyStimulus(8'h3C, 1'b0, 1'b1, 11);
        checkOutput("t5_seq_e", 32'(seq_state), 0);

        // 6: abort mid-payload keeps the pending word, then reset clears everything
        $display("[TB] test 6: abort and reset");
        out_ready = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b1, 11);
        applyStimulus(8'h00, 1'b0, 1'b1, 11);
        applyStimulus(8'h5A, 1'b0, 1'b1, 11);
        applyStimulus(8'h00, 1'b1, 1'b1, 11);
        applyStimulus(8'h00, 1'b0, 1'b1, 11);
        applyStimulus(8'hC3, 1'b0, 1'b1, 5);
        checkOutput("t6_busy_mid", 32'(busy), 1);
        checkOutput("t6_seq_mid", 32'(seq_state), 2);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("t6_busy_abort", 32'(busy), 0);
        checkOutput("t6_seq_abort", 32'(seq_state), 0);
        checkOutput("t6_valid_kept", 32'(out_valid), 1);
        checkOutput("t6_data_kept", 32'(out_data), 32'h5A);
        signal = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t6_rst_valid", 32'(out_valid), 0);
        checkOutput("t6_rst_data", 32'(out_data), 0);
        checkOutput("t6_rst_seq", 32'(seq_state), 0);
        checkOutput("t6_rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t6_post_valid", 32'(out_valid), 0);
        checkOutput("final_queue_empty", 32'(expQ.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
